grid_cursor_selector: RTL and testbench



---
 rtl/grid_cursor_selector_if.sv | 21 ++
 rtl/grid_cursor_selector.sv | 128 ++++++++++++
 tb/tb_grid_cursor_selector.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_cursor_selector_if.sv
// Handshake bundle between the key/debounce front end, the cursor selector and the game-state logic.
// The master side drives the board and key levels; the slave side is the selector.
interface grid_cursor_selector_if #(
  parameter int DIM = 3,
  parameter int IW  = $clog2(DIM*DIM)
);
  logic [DIM*DIM-1:0][1:0] board;
  logic                    next;
  logic                    prev;
  logic                    sel;
  logic [IW-1:0]           curBox;
  logic                    valid;
  logic                    board_full;
  logic                    place_strobe;
  logic [15:0][15:0]       GrnPixels;

  modport master (output board, next, prev, sel,
                  input  curBox, valid, board_full, place_strobe, GrnPixels);
  modport slave  (input  board, next, prev, sel,
                  output curBox, valid, board_full, place_strobe, GrnPixels);
endinterface

// File: rtl/grid_cursor_selector.sv
// Cursor over a DIM x DIM board: skips to the next empty cell, blinks it on the LED plane,
// and emits a one-cycle placement strobe on confirm.
module grid_cursor_selector #(
  parameter int DIM     = 3,
  parameter int CELL_PX = 5,
  parameter int BLINK_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  grid_cursor_selector_if.slave bus
);
  localparam int N  = DIM*DIM;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {SEEK_F, SEEK_B, HOLD, FULL} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     cur, cur_nx, cur_inc, cur_dec;
  logic [IW:0]       scan, scan_nx;
  logic              next_q, prev_q, sel_q;
  logic              next_ev, prev_ev, sel_ev;
  logic              strobe, strobe_nx;
  logic [N-1:0]      empty;
  logic              cur_empty, any_empty, valid_w, show;
  logic [BLINK_W-1:0] blink;
  logic [15:0][15:0] pix, pix_nx;
  logic [15:0]       row_m, col_m;
  int                rlo, clo;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign empty[i] = (bus.board[i] == 2'b00);
  end

  assign cur_empty = empty[cur];
  assign any_empty = |empty;
  assign cur_inc   = (cur == IW'(N-1)) ? '0 : cur + 1'b1;
  assign cur_dec   = (cur == '0) ? IW'(N-1) : cur - 1'b1;
  assign next_ev   = bus.next & ~next_q;
  assign prev_ev   = bus.prev & ~prev_q;
  assign sel_ev    = bus.sel  & ~sel_q;
  assign valid_w   = (state == HOLD) && cur_empty;

  always_comb begin
    state_nx  = state;
    cur_nx    = cur;
    scan_nx   = scan;
    strobe_nx = 1'b0;
    case (state)
      SEEK_F, SEEK_B: begin
        if (cur_empty) begin
          state_nx = HOLD;
        end else begin
          cur_nx  = (state == SEEK_F) ? cur_inc : cur_dec;
          scan_nx = scan + 1'b1;
          if (scan + 1'b1 == (IW+1)'(N)) state_nx = FULL;
        end
      end
      HOLD: begin
        // An external placement on our cell outranks any key event this cycle.
        if (!cur_empty) begin
          state_nx = SEEK_F;
          scan_nx  = '0;
        end else if (sel_ev) begin
          strobe_nx = 1'b1;
        end else if (next_ev && !prev_ev) begin
          cur_nx   = cur_inc;
          scan_nx  = '0;
          state_nx = SEEK_F;
        end else if (prev_ev && !next_ev) begin
          cur_nx   = cur_dec;
          scan_nx  = '0;
          state_nx = SEEK_B;
        end
      end
      FULL: begin
        if (any_empty) begin
          scan_nx  = '0;
          state_nx = SEEK_F;
        end
      end
      default: state_nx = SEEK_F;
    endcase
  end

  // Cursor square spans CELL_PX-1 pixels; the last row/column of each pitch is a gap.
  always_comb begin
    rlo  = (int'(cur) / DIM) * CELL_PX;
    clo  = (int'(cur) % DIM) * CELL_PX;
    show = valid_w && blink[BLINK_W-1];
    for (int i = 0; i < 16; i++) begin
      row_m[i] = (i >= rlo) && (i <= rlo + CELL_PX - 2);
      col_m[i] = (i >= clo) && (i <= clo + CELL_PX - 2);
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        pix_nx[r][c] = show & row_m[r] & col_m[c];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SEEK_F;
      cur    <= '0;
      scan   <= '0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
      sel_q  <= 1'b0;
      strobe <= 1'b0;
      blink  <= '0;
      pix    <= '0;
    end else begin
      state  <= state_nx;
      cur    <= cur_nx;
      scan   <= scan_nx;
      next_q <= bus.next;
      prev_q <= bus.prev;
      sel_q  <= bus.sel;
      strobe <= strobe_nx;
      blink  <= blink + 1'b1;
      pix    <= pix_nx;
    end
  end

  assign bus.curBox       = cur;
  assign bus.valid        = valid_w;
  assign bus.board_full   = (state == FULL);
  assign bus.place_strobe = strobe;
  assign bus.GrnPixels    = pix;
endmodule

// File: tb/tb_grid_cursor_selector.sv
// Directed bench for grid_cursor_selector with DIM=3, CELL_PX=5, BLINK_W=3.
module tb_grid_cursor_selector;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;

  grid_cursor_selector_if #(.DIM(3)) bus ();

  grid_cursor_selector #(.DIM(3), .CELL_PX(5), .BLINK_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.next = 1'b0; bus.prev = 1'b0; bus.sel = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_hold(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.valid === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic move(input bit fwd, output bit ok);
    if (fwd) bus.next = 1'b1; else bus.prev = 1'b1;
    tick();
    bus.next = 1'b0; bus.prev = 1'b0;
    wait_hold(ok);
  endtask

  task automatic test_reset();
    bus.board = '0;
    do_reset();
    reset = 1'b1; #1;
    total++;
    if (bus.curBox !== 4'd0 || bus.valid !== 1'b0 || bus.board_full !== 1'b0 ||
        bus.place_strobe !== 1'b0 || bus.GrnPixels !== '0)
      $display("FAIL reset_values cur=%0d valid=%b full=%b strobe=%b pix=%h want 0,0,0,0,0",
               bus.curBox, bus.valid, bus.board_full, bus.place_strobe, bus.GrnPixels);
    else passed++;
    reset = 1'b0;
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.curBox !== 4'd0)
      $display("FAIL first_hold valid=%b cur=%0d want valid=1 cur=0", bus.valid, bus.curBox);
    else passed++;
  endtask

  task automatic test_walk_empty();
    int exp_seq [11];
    bit ok;
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2};
    for (int i = 0; i < 11; i++) begin
      move(1'b1, ok);
      total++;
      if (!ok || bus.curBox !== 4'(exp_seq[i]))
        $display("FAIL walk_next[%0d] cur=%0d ok=%b want %0d", i, bus.curBox, ok, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_skip_occupied();
    int exp_seq [6];
    bit ok;
    exp_seq = '{3, 4, 6, 7, 8, 1};
    bus.board = '0;
    bus.board[0] = 2'b01; bus.board[2] = 2'b01; bus.board[5] = 2'b01;
    do_reset();
    wait_hold(ok);
    total++;
    if (!ok || bus.curBox !== 4'd1)
      $display("FAIL skip_initial cur=%0d ok=%b want 1", bus.curBox, ok);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      move(1'b1, ok);
      total++;
      if (!ok || bus.curBox !== 4'(exp_seq[i]))
        $display("FAIL skip_next[%0d] cur=%0d ok=%b want %0d", i, bus.curBox, ok, exp_seq[i]);
      else passed++;
    end
    move(1'b0, ok);
    total++;
    if (!ok || bus.curBox !== 4'd8)
      $display("FAIL skip_prev_wrap cur=%0d ok=%b want 8", bus.curBox, ok);
    else passed++;
  endtask

  task automatic test_external_place();
    bit ok;
    int strobes = 0;
    move(1'b1, ok); move(1'b1, ok); move(1'b1, ok);
    total++;
    if (!ok || bus.curBox !== 4'd4)
      $display("FAIL ext_setup cur=%0d ok=%b want 4", bus.curBox, ok);
    else passed++;
    bus.board[4] = 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.place_strobe === 1'b1) strobes++;
      if (bus.valid === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || bus.curBox !== 4'd6)
      $display("FAIL ext_reseek cur=%0d ok=%b want 6", bus.curBox, ok);
    else passed++;
    total++;
    if (strobes !== 0) $display("FAIL ext_no_strobe strobes=%0d want 0", strobes);
    else passed++;
  endtask

  task automatic test_select();
    bit ok;
    int strobes = 0;
    move(1'b1, ok); move(1'b1, ok); move(1'b1, ok);
    total++;
    if (!ok || bus.curBox !== 4'd1)
      $display("FAIL sel_setup cur=%0d ok=%b want 1", bus.curBox, ok);
    else passed++;
    bus.sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.place_strobe === 1'b1) strobes++;
    end
    bus.sel = 1'b0;
    tick();
    if (bus.place_strobe === 1'b1) strobes++;
    total++;
    if (strobes !== 1) $display("FAIL sel_held_strobes count=%0d want 1", strobes);
    else passed++;
    total++;
    if (bus.curBox !== 4'd1) $display("FAIL sel_held_cur cur=%0d want 1", bus.curBox);
    else passed++;
    bus.next = 1'b1; bus.sel = 1'b1;
    tick();
    total++;
    if (bus.place_strobe !== 1'b1) $display("FAIL sel_next_strobe strobe=%b want 1", bus.place_strobe);
    else passed++;
    bus.next = 1'b0; bus.sel = 1'b0;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.place_strobe === 1'b1) strobes++;
    end
    total++;
    if (bus.curBox !== 4'd1 || bus.valid !== 1'b1 || strobes !== 0)
      $display("FAIL sel_next_nomove cur=%0d valid=%b extra=%0d want 1,1,0",
               bus.curBox, bus.valid, strobes);
    else passed++;
  endtask

  task automatic test_full();
    bit ok;
    bus.board = '0;
    for (int i = 0; i < 9; i++) bus.board[i] = 2'b10;
    bus.board[2] = 2'b01; bus.board[5] = 2'b01; bus.board[7] = 2'b00;
    do_reset();
    wait_hold(ok);
    total++;
    if (!ok || bus.curBox !== 4'd7)
      $display("FAIL full_settle cur=%0d ok=%b want 7", bus.curBox, ok);
    else passed++;
    bus.board[7] = 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.board_full === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || bus.valid !== 1'b0 || bus.GrnPixels !== '0)
      $display("FAIL full_state ok=%b valid=%b pix=%h want 1,0,0", ok, bus.valid, bus.GrnPixels);
    else passed++;
    total++;
    if (bus.curBox !== 4'd7) $display("FAIL full_cur cur=%0d want 7", bus.curBox);
    else passed++;
    bus.board[3] = 2'b00;
    wait_hold(ok);
    total++;
    if (!ok || bus.curBox !== 4'd3 || bus.board_full !== 1'b0)
      $display("FAIL full_exit cur=%0d ok=%b full=%b want 3,1,0", bus.curBox, ok, bus.board_full);
    else passed++;
  endtask

  task automatic test_blink_and_reset();
    bit ok;
    logic [15:0][15:0] exp_m;
    bit lit [16];
    int last_chg, n_lit;
    bus.board = '0;
    do_reset();
    wait_hold(ok);
    for (int i = 0; i < 4; i++) move(1'b1, ok);
    total++;
    if (!ok || bus.curBox !== 4'd4) $display("FAIL blink_setup cur=%0d want 4", bus.curBox);
    else passed++;
    exp_m = '0;
    for (int r = 5; r <= 8; r++)
      for (int c = 5; c <= 8; c++) exp_m[r][c] = 1'b1;
    n_lit = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      lit[i] = (bus.GrnPixels === exp_m);
      if (lit[i]) n_lit++;
      total++;
      if (!lit[i] && bus.GrnPixels !== '0)
        $display("FAIL blink_pattern[%0d] pix=%h want %h or 0", i, bus.GrnPixels, exp_m);
      else passed++;
    end
    total++;
    if (n_lit !== 8) $display("FAIL blink_duty lit=%0d want 8", n_lit);
    else passed++;
    last_chg = -1;
    for (int i = 1; i < 16; i++) begin
      if (lit[i] != lit[i-1]) begin
        if (last_chg >= 0) begin
          total++;
          if (i - last_chg !== 4) $display("FAIL blink_period got=%0d want 4", i - last_chg);
          else passed++;
        end
        last_chg = i;
      end
    end
    // Reset while seeking across occupied cells 5..7.
    bus.board[5] = 2'b01; bus.board[6] = 2'b01; bus.board[7] = 2'b01;
    bus.next = 1'b1;
    tick();
    bus.next = 1'b0;
    tick();
    reset = 1'b1; #1;
    total++;
    if (bus.curBox !== 4'd0 || bus.valid !== 1'b0 || bus.board_full !== 1'b0 ||
        bus.place_strobe !== 1'b0 || bus.GrnPixels !== '0)
      $display("FAIL reset_mid_seek cur=%0d valid=%b full=%b strobe=%b pix=%h want all 0",
               bus.curBox, bus.valid, bus.board_full, bus.place_strobe, bus.GrnPixels);
    else passed++;
    reset = 1'b0;
    bus.board = '0;
    wait_hold(ok);
    bus.sel = 1'b1;
    tick();
    total++;
    if (bus.place_strobe !== 1'b1) $display("FAIL strobe_before_reset strobe=%b want 1", bus.place_strobe);
    else passed++;
    reset = 1'b1; #1;
    total++;
    if (bus.place_strobe !== 1'b0) $display("FAIL reset_mid_strobe strobe=%b want 0", bus.place_strobe);
    else passed++;
    reset = 1'b0;
    n_lit = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.place_strobe === 1'b1) n_lit++;
    end
    bus.sel = 1'b0;
    total++;
    if (n_lit !== 0) $display("FAIL strobe_not_extended count=%0d want 0", n_lit);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus.board = '0; bus.next = 1'b0; bus.prev = 1'b0; bus.sel = 1'b0;
    test_reset();
    test_walk_empty();
    test_skip_occupied();
    test_external_place();
    test_select();
    test_full();
    test_blink_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
